ddr_burst_arbiter: RTL and testbench

Parametrised N-channel burst arbiter and app-interface sequencer. It sits between the cache-side burst requesters (instruction cache, data cache, interrupt-instruction loader) and the MIG 7-series user interface, and replaces the single-requester burst controller. It grants one channel at a time by round-robin, runs a read or write burst of programmable length on the app interface, and routes beats and completion back to the granted channel.

---
 rtl/ddr_burst_arbiter_if.sv | 27 ++
 rtl/ddr_burst_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ddr_burst_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_burst_arbiter_if.sv
// MIG 7-series app-side user interface bundle used by ddr_burst_arbiter.
interface ddr_burst_arbiter_if #(
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28
);
    logic                          app_en;
    logic [2:0]                    app_cmd;
    logic [DDR_ADDR_WIDTH-1:0]     app_addr;
    logic                          app_rdy;
    logic                          app_wdf_wren;
    logic                          app_wdf_end;
    logic [DDR_DATA_WIDTH-1:0]     app_wdf_data;
    logic [DDR_DATA_WIDTH/8-1:0]   app_wdf_mask;
    logic                          app_wdf_rdy;
    logic [DDR_DATA_WIDTH-1:0]     app_rd_data;
    logic                          app_rd_data_valid;

    modport master (
        output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/ddr_burst_arbiter.sv
// N-channel round-robin burst arbiter driving the MIG app interface.
// Define DDR_ARB_FIXED_PRIO_EN for fixed priority (lowest channel index wins).
//
// state   | meaning
// IDLE    | arbitrate among eligible channels, latch burst parameters
// RD      | issue read commands until len commands accepted
// RD_WAIT | collect remaining read beats until len beats returned
// WR      | issue write command + data beats until len accepted
// DONE    | pulse finish, advance round-robin pointer
module ddr_burst_arbiter #(
    parameter int NUM_CH         = 3,
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH      = 10,
    parameter int ADDR_STEP      = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               init_calib_complete,
    input  logic [NUM_CH-1:0]                  ch_rd_req,
    input  logic [NUM_CH-1:0]                  ch_wr_req,
    input  logic [NUM_CH*LEN_WIDTH-1:0]        ch_len,
    input  logic [NUM_CH*DDR_ADDR_WIDTH-1:0]   ch_addr,
    input  logic [NUM_CH*DDR_DATA_WIDTH-1:0]   ch_wr_data,
    output logic [NUM_CH-1:0]                  ch_grant,
    output logic [NUM_CH-1:0]                  ch_wr_data_req,
    output logic [DDR_DATA_WIDTH-1:0]          ch_rd_data,
    output logic [NUM_CH-1:0]                  ch_rd_data_valid,
    output logic [NUM_CH-1:0]                  ch_finish,
    ddr_burst_arbiter_if.master                app
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = LEN_WIDTH + 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_WAIT, S_WR, S_DONE} state_t;
    state_t state, state_nxt;

    logic [CH_W-1:0]           ch_q, rr_ptr, win_idx;
    logic                      win_found, win_rd;
    logic [LEN_WIDTH-1:0]      win_len;
    logic [DDR_ADDR_WIDTH-1:0] win_addr, addr_q;
    logic [CNT_W-1:0]          len_q, cmd_cnt, rd_cnt;
    logic                      cmd_acc, wr_acc, rd_beat, last_cmd;
    logic [NUM_CH-1:0]         ch_onehot;

    always_comb begin : arbitrate
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        win_rd    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef DDR_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = (int'(rr_ptr) + 1 + i) % NUM_CH;
`endif
            if (!win_found && (ch_rd_req[idx] || ch_wr_req[idx])) begin
                win_found = 1'b1;
                win_idx   = CH_W'(idx);
                win_rd    = ch_rd_req[idx];
            end
        end
        win_found = win_found & init_calib_complete;
    end

    assign win_len   = ch_len[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
    assign win_addr  = ch_addr[int'(win_idx)*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
    assign ch_onehot = NUM_CH'(1) << ch_q;

    assign cmd_acc  = (state == S_RD) && app.app_rdy;
    assign wr_acc   = (state == S_WR) && app.app_rdy && app.app_wdf_rdy;
    assign rd_beat  = ((state == S_RD) || (state == S_RD_WAIT)) && app.app_rd_data_valid
                      && (rd_cnt < len_q);
    assign last_cmd = ((cmd_cnt + CNT_W'(1)) == len_q);

    assign app.app_addr     = addr_q;
    assign app.app_wdf_mask = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        app.app_en         = 1'b0;
        app.app_cmd        = 3'b000;
        app.app_wdf_wren   = 1'b0;
        app.app_wdf_end    = 1'b0;
        app.app_wdf_data   = '0;
        ch_grant           = '0;
        ch_finish          = '0;
        ch_wr_data_req     = '0;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    if (win_len == '0) state_nxt = S_DONE;
                    else if (win_rd)   state_nxt = S_RD;
                    else               state_nxt = S_WR;
                end
            end
            S_RD: begin
                ch_grant    = ch_onehot;
                app.app_en  = 1'b1;
                app.app_cmd = 3'b001;
                if (cmd_acc && last_cmd) state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                ch_grant = ch_onehot;
                if (rd_cnt == len_q) state_nxt = S_DONE;
            end
            S_WR: begin
                ch_grant         = ch_onehot;
                app.app_en       = 1'b1;
                app.app_wdf_wren = 1'b1;
                app.app_wdf_end  = 1'b1;
                app.app_wdf_data = ch_wr_data[int'(ch_q)*DDR_DATA_WIDTH +: DDR_DATA_WIDTH];
                if (wr_acc) begin
                    ch_wr_data_req = ch_onehot;
                    if (last_cmd) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ch_grant  = ch_onehot;
                ch_finish = ch_onehot;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Reset pointer to the last channel so channel 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q             <= '0;
            rr_ptr           <= CH_W'(NUM_CH - 1);
            len_q            <= '0;
            addr_q           <= '0;
            cmd_cnt          <= '0;
            rd_cnt           <= '0;
            ch_rd_data       <= '0;
            ch_rd_data_valid <= '0;
        end else begin
            ch_rd_data_valid <= '0;
            if ((state == S_IDLE) && win_found) begin
                ch_q    <= win_idx;
                len_q   <= {1'b0, win_len};
                addr_q  <= win_addr;
                cmd_cnt <= '0;
                rd_cnt  <= '0;
            end
            if (cmd_acc || wr_acc) begin
                addr_q  <= addr_q + DDR_ADDR_WIDTH'(ADDR_STEP);
                cmd_cnt <= cmd_cnt + CNT_W'(1);
            end
            if (rd_beat) begin
                ch_rd_data       <= app.app_rd_data;
                ch_rd_data_valid <= ch_onehot;
                rd_cnt           <= rd_cnt + CNT_W'(1);
            end
            if (state == S_DONE) rr_ptr <= ch_q;
        end
    end
endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed self-checking bench for ddr_burst_arbiter.
module tb_ddr_burst_arbiter;
    localparam int NUM_CH = 3;
    localparam int DW     = 128;
    localparam int AW     = 28;
    localparam int LW     = 10;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   init_calib_complete;
    logic [NUM_CH-1:0]      ch_rd_req, ch_wr_req;
    logic [NUM_CH*LW-1:0]   ch_len;
    logic [NUM_CH*AW-1:0]   ch_addr;
    logic [NUM_CH*DW-1:0]   ch_wr_data;
    logic [NUM_CH-1:0]      ch_grant, ch_wr_data_req, ch_rd_data_valid, ch_finish;
    logic [DW-1:0]          ch_rd_data;
    int                     pass_cnt = 0;
    int                     total_cnt = 0;

    ddr_burst_arbiter_if #(.DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW)) app ();

    ddr_burst_arbiter #(
        .NUM_CH(NUM_CH), .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ADDR_STEP(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
        .ch_rd_req(ch_rd_req), .ch_wr_req(ch_wr_req), .ch_len(ch_len), .ch_addr(ch_addr),
        .ch_wr_data(ch_wr_data), .ch_grant(ch_grant), .ch_wr_data_req(ch_wr_data_req),
        .ch_rd_data(ch_rd_data), .ch_rd_data_valid(ch_rd_data_valid), .ch_finish(ch_finish),
        .app(app)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ch_rd_req = '0; ch_wr_req = '0; ch_len = '0; ch_addr = '0; ch_wr_data = '0;
        app.app_rdy = 1'b0; app.app_wdf_rdy = 1'b0;
        app.app_rd_data = '0; app.app_rd_data_valid = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        init_calib_complete = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        init_calib_complete = 1'b0;
        rst_n = 1'b0;
        #3;
        total_cnt++;
        if ({ch_grant, ch_finish, ch_rd_data_valid, ch_wr_data_req} !== 12'h000)
            $display("FAIL reset_ch_outs: got %h expected 000", {ch_grant, ch_finish, ch_rd_data_valid, ch_wr_data_req});
        else pass_cnt++;
        total_cnt++;
        if ({app.app_en, app.app_cmd, app.app_wdf_wren, app.app_wdf_end} !== 6'b0)
            $display("FAIL reset_app_ctrl: got %b expected 000000", {app.app_en, app.app_cmd, app.app_wdf_wren, app.app_wdf_end});
        else pass_cnt++;
        total_cnt++;
        if (app.app_addr !== 28'h0 || ch_rd_data !== 128'h0)
            $display("FAIL reset_addr_data: got addr %h data %h expected 0", app.app_addr, ch_rd_data);
        else pass_cnt++;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (ch_grant !== 3'b000) $display("FAIL reset_idle_grant: got %b expected 000", ch_grant);
        else pass_cnt++;
    endtask

    task automatic test_single_read();
        logic [DW-1:0] exp_d;
        init_calib_complete = 1'b1;
        ch_len[1*LW +: LW]  = 10'd4;
        ch_addr[1*AW +: AW] = 28'h100;
        ch_rd_req = 3'b010;
        app.app_rdy = 1'b1;
        tick();
        ch_rd_req = 3'b000;
        ch_len[1*LW +: LW] = 10'd9;
        total_cnt++;
        if (ch_grant !== 3'b010) $display("FAIL rd_grant: got %b expected 010", ch_grant);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if ({app.app_en, app.app_cmd} !== 4'b1001)
                $display("FAIL rd_cmd%0d: got %b expected 1001", i, {app.app_en, app.app_cmd});
            else pass_cnt++;
            total_cnt++;
            if (app.app_addr !== AW'(32'h100 + 8 * i))
                $display("FAIL rd_addr%0d: got %h expected %h", i, app.app_addr, AW'(32'h100 + 8 * i));
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (app.app_en !== 1'b0 || ch_grant !== 3'b010)
            $display("FAIL rd_wait_state: got en %b grant %b expected 0 010", app.app_en, ch_grant);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            exp_d = DW'(32'hA000_0000 + i);
            app.app_rd_data = exp_d;
            app.app_rd_data_valid = 1'b1;
            tick();
            app.app_rd_data_valid = 1'b0;
            total_cnt++;
            if (ch_rd_data_valid !== 3'b010 || ch_rd_data !== exp_d)
                $display("FAIL rd_beat%0d: got valid %b data %h expected 010 %h", i, ch_rd_data_valid, ch_rd_data, exp_d);
            else pass_cnt++;
            total_cnt++;
            if (ch_finish !== 3'b000) $display("FAIL rd_early_finish%0d: got %b expected 000", i, ch_finish);
            else pass_cnt++;
        end
        tick();
        total_cnt++;
        if (ch_finish !== 3'b010 || ch_grant !== 3'b010 || ch_rd_data_valid !== 3'b000)
            $display("FAIL rd_finish: got fin %b grant %b vld %b expected 010 010 000", ch_finish, ch_grant, ch_rd_data_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ch_finish !== 3'b000 || ch_grant !== 3'b000)
            $display("FAIL rd_after_finish: got fin %b grant %b expected 000 000", ch_finish, ch_grant);
        else pass_cnt++;
    endtask

    task automatic test_write_backpressure();
        logic [DW-1:0] exp_d;
        int acc = 0;
        int cyc = 0;
        int req_pulses = 0;
        ch_len[0 +: LW]  = 10'd3;
        ch_addr[0 +: AW] = 28'h40;
        ch_wr_data[1*DW +: DW] = {DW{1'b1}};
        ch_wr_data[0 +: DW] = DW'(32'hBEEF_0000);
        ch_wr_req = 3'b001;
        app.app_rdy = 1'b1;
        app.app_wdf_rdy = 1'b0;
        tick();
        ch_wr_req = 3'b000;
        total_cnt++;
        if (ch_grant !== 3'b001) $display("FAIL wr_grant: got %b expected 001", ch_grant);
        else pass_cnt++;
        while (acc < 3 && cyc < 20) begin
            app.app_wdf_rdy = (cyc % 2) == 1;
            exp_d = DW'(32'hBEEF_0000 + acc);
            ch_wr_data[0 +: DW] = exp_d;
            #1;
            total_cnt++;
            if ({app.app_en, app.app_wdf_wren, app.app_wdf_end, app.app_cmd} !== 6'b111000 || app.app_wdf_mask !== 16'h0)
                $display("FAIL wr_ctrl%0d: got %b mask %h expected 111000 0", cyc, {app.app_en, app.app_wdf_wren, app.app_wdf_end, app.app_cmd}, app.app_wdf_mask);
            else pass_cnt++;
            total_cnt++;
            if (app.app_wdf_data !== exp_d) $display("FAIL wr_data%0d: got %h expected %h", cyc, app.app_wdf_data, exp_d);
            else pass_cnt++;
            total_cnt++;
            if (ch_wr_data_req !== (app.app_wdf_rdy ? 3'b001 : 3'b000))
                $display("FAIL wr_req%0d: got %b expected %b", cyc, ch_wr_data_req, app.app_wdf_rdy ? 3'b001 : 3'b000);
            else pass_cnt++;
            total_cnt++;
            if (app.app_addr !== AW'(32'h40 + 8 * acc))
                $display("FAIL wr_addr%0d: got %h expected %h", cyc, app.app_addr, AW'(32'h40 + 8 * acc));
            else pass_cnt++;
            if (ch_wr_data_req[0]) req_pulses++;
            if (app.app_wdf_rdy) acc++;
            cyc++;
            tick();
        end
        app.app_wdf_rdy = 1'b0;
        total_cnt++;
        if (req_pulses !== 3) $display("FAIL wr_req_count: got %0d expected 3", req_pulses);
        else pass_cnt++;
        total_cnt++;
        if (ch_finish !== 3'b001 || app.app_en !== 1'b0)
            $display("FAIL wr_finish: got fin %b en %b expected 001 0", ch_finish, app.app_en);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (ch_finish !== 3'b000 || ch_grant !== 3'b000)
            $display("FAIL wr_after_finish: got fin %b grant %b expected 000 000", ch_finish, ch_grant);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [NUM_CH-1:0] exp_g [4];
        int n;
`ifdef DDR_ARB_FIXED_PRIO_EN
        exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
`else
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
`endif
        apply_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            ch_len[c*LW +: LW]  = 10'd1;
            ch_addr[c*AW +: AW] = AW'(32'h1000 * c);
        end
        ch_rd_req = 3'b111;
        app.app_rdy = 1'b1;
        for (int b = 0; b < 4; b++) begin
            n = 0;
            while (ch_grant == 3'b000 && n < 10) begin tick(); n++; end
            total_cnt++;
            if (ch_grant !== exp_g[b]) $display("FAIL rr_grant%0d: got %b expected %b", b, ch_grant, exp_g[b]);
            else pass_cnt++;
            app.app_rd_data_valid = 1'b1;
            tick();
            app.app_rd_data_valid = 1'b0;
            n = 0;
            while (ch_finish == 3'b000 && n < 10) begin tick(); n++; end
            total_cnt++;
            if (ch_finish !== exp_g[b]) $display("FAIL rr_finish%0d: got %b expected %b", b, ch_finish, exp_g[b]);
            else pass_cnt++;
            tick();
        end
        ch_rd_req = 3'b000;
        repeat (3) tick();
    endtask

    task automatic test_calib_gate();
        init_calib_complete = 1'b0;
        ch_len[2*LW +: LW] = 10'd1;
        ch_rd_req = 3'b100;
        app.app_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (ch_grant !== 3'b000 || app.app_en !== 1'b0)
                $display("FAIL calib_block%0d: got grant %b en %b expected 000 0", i, ch_grant, app.app_en);
            else pass_cnt++;
        end
        init_calib_complete = 1'b1;
        tick();
        total_cnt++;
        if (ch_grant !== 3'b100) $display("FAIL calib_grant: got %b expected 100", ch_grant);
        else pass_cnt++;
        app.app_rd_data_valid = 1'b1;
        tick();
        app.app_rd_data_valid = 1'b0;
        ch_rd_req = 3'b000;
        tick();
        total_cnt++;
        if (ch_finish !== 3'b100) $display("FAIL calib_finish: got %b expected 100", ch_finish);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_rd_wr_priority();
        ch_len[2*LW +: LW]  = 10'd2;
        ch_addr[2*AW +: AW] = 28'h300;
        ch_wr_data[2*DW +: DW] = DW'(32'hCAFE_0000);
        ch_rd_req = 3'b100;
        ch_wr_req = 3'b100;
        app.app_rdy = 1'b1;
        app.app_wdf_rdy = 1'b1;
        tick();
        total_cnt++;
        if (ch_grant !== 3'b100 || {app.app_en, app.app_wdf_wren, app.app_cmd} !== 5'b10001)
            $display("FAIL prio_read_first: got grant %b ctrl %b expected 100 10001", ch_grant, {app.app_en, app.app_wdf_wren, app.app_cmd});
        else pass_cnt++;
        ch_rd_req = 3'b000;
        app.app_rd_data_valid = 1'b1;
        tick();
        tick();
        app.app_rd_data_valid = 1'b0;
        tick();
        total_cnt++;
        if (ch_finish !== 3'b100) $display("FAIL prio_rd_finish: got %b expected 100", ch_finish);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (ch_grant !== 3'b100 || {app.app_en, app.app_wdf_wren, app.app_cmd} !== 5'b11000 || app.app_addr !== 28'h300)
            $display("FAIL prio_write_next: got grant %b ctrl %b addr %h expected 100 11000 300", ch_grant, {app.app_en, app.app_wdf_wren, app.app_cmd}, app.app_addr);
        else pass_cnt++;
        ch_wr_req = 3'b000;
        tick();
        tick();
        total_cnt++;
        if (ch_finish !== 3'b100) $display("FAIL prio_wr_finish: got %b expected 100", ch_finish);
        else pass_cnt++;
        app.app_wdf_rdy = 1'b0;
        tick();
    endtask

    task automatic test_len_zero();
        int en_cycles = 0;
        ch_len[1*LW +: LW] = 10'd0;
        ch_rd_req = 3'b010;
        tick();
        if (app.app_en) en_cycles++;
        total_cnt++;
        if (ch_finish !== 3'b010 || ch_grant !== 3'b010)
            $display("FAIL len0_finish: got fin %b grant %b expected 010 010", ch_finish, ch_grant);
        else pass_cnt++;
        ch_rd_req = 3'b000;
        tick();
        if (app.app_en) en_cycles++;
        total_cnt++;
        if (ch_finish !== 3'b000 || ch_grant !== 3'b000)
            $display("FAIL len0_after: got fin %b grant %b expected 000 000", ch_finish, ch_grant);
        else pass_cnt++;
        tick();
        if (app.app_en) en_cycles++;
        total_cnt++;
        if (en_cycles !== 0) $display("FAIL len0_app_en: got %0d cycles expected 0", en_cycles);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        ch_len[1*LW +: LW]  = 10'd2;
        ch_addr[1*AW +: AW] = 28'h200;
        ch_rd_req = 3'b010;
        app.app_rdy = 1'b1;
        tick();
        ch_rd_req = 3'b000;
        tick();
        tick();
        total_cnt++;
        if (ch_grant !== 3'b010 || app.app_en !== 1'b0)
            $display("FAIL mid_rd_wait: got grant %b en %b expected 010 0", ch_grant, app.app_en);
        else pass_cnt++;
        app.app_rd_data = DW'(32'h5555_AAAA);
        app.app_rd_data_valid = 1'b1;
        tick();
        app.app_rd_data_valid = 1'b0;
        total_cnt++;
        if (ch_rd_data_valid !== 3'b010) $display("FAIL mid_beat: got %b expected 010", ch_rd_data_valid);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({ch_grant, ch_rd_data_valid, ch_finish, app.app_en} !== 10'h0 || ch_rd_data !== 128'h0 || app.app_addr !== 28'h0)
            $display("FAIL mid_async_clear: got %b data %h addr %h expected 0", {ch_grant, ch_rd_data_valid, ch_finish, app.app_en}, ch_rd_data, app.app_addr);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        ch_len[0 +: LW] = 10'd1;
        ch_len[1*LW +: LW] = 10'd1;
        ch_rd_req = 3'b011;
        tick();
        total_cnt++;
        if (ch_grant !== 3'b001) $display("FAIL mid_first_grant: got %b expected 001", ch_grant);
        else pass_cnt++;
        app.app_rd_data_valid = 1'b1;
        tick();
        app.app_rd_data_valid = 1'b0;
        ch_rd_req = 3'b000;
        tick();
        total_cnt++;
        if (ch_finish !== 3'b001) $display("FAIL mid_finish: got %b expected 001", ch_finish);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_backpressure();
        test_round_robin();
        test_calib_gate();
        test_rd_wr_priority();
        test_len_zero();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
